// File: rtl/flappy_ssd_pkg.sv
// Shared constants for the score seven-segment driver: segment codes, FSM states, digit indices.
// Segment codes are {a,b,c,d,e,f,g,dp}, active-low, with the decimal point off.
package flappy_ssd_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam logic [7:0] SEG_0     = 8'b0000001_1;
    localparam logic [7:0] SEG_1     = 8'b1001111_1;
    localparam logic [7:0] SEG_2     = 8'b0010010_1;
    localparam logic [7:0] SEG_3     = 8'b0000110_1;
    localparam logic [7:0] SEG_4     = 8'b1001100_1;
    localparam logic [7:0] SEG_5     = 8'b0100100_1;
    localparam logic [7:0] SEG_6     = 8'b0100000_1;
    localparam logic [7:0] SEG_7     = 8'b0001111_1;
    localparam logic [7:0] SEG_8     = 8'b0000000_1;
    localparam logic [7:0] SEG_9     = 8'b0000100_1;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [1:0] DIGIT_ONES      = 2'd0;
    localparam logic [1:0] DIGIT_TENS      = 2'd1;
    localparam logic [1:0] DIGIT_HUNDREDS  = 2'd2;
    localparam logic [1:0] DIGIT_THOUSANDS = 2'd3;

    function automatic logic [7:0] seg_encode(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_inc4.sv
// Combinational four-digit BCD increment; holds at 9999 and flags saturation.
module bcd_inc4 (
    input  logic [15:0] value,
    output logic [15:0] value_next,
    output logic        saturated
);

    logic [3:0]  carry;
    logic [15:0] sum;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] nib;
            assign nib = value[gi*4 +: 4];
            assign sum[gi*4 +: 4] = !carry[gi]      ? nib  :
                                    (nib == 4'd9)   ? 4'd0 : nib + 4'd1;
            if (gi < 3) begin : g_carry
                assign carry[gi+1] = carry[gi] && (nib == 4'd9);
            end
        end
    endgenerate

    assign saturated  = (value == 16'h9999);
    assign value_next = saturated ? value : sum;

endmodule

// File: rtl/score_ssd_driver.sv
// Score/high-score keeper and multiplexed 4-digit seven-segment driver for the flappy game.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module score_ssd_driver
    import flappy_ssd_pkg::*;
#(
    parameter int SCAN_DIV_W  = 18,
    parameter int BLINK_DIV_W = 26
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        score_pulse,
    input  logic        lose,
    input  logic        clear,
    output logic [3:0]  An,
    output logic [7:0]  Cathodes,
    output logic [15:0] score_bcd,
    output logic [15:0] high_bcd,
    output logic        game_over
);

    state_t state_reg, state_next;
    logic   lose_d_reg;
    logic   over_entry_reg;
    logic   lose_rise;
    logic   in_play;
    logic   enter_over;

    logic [SCAN_DIV_W+1:0] scan_cnt_reg;
    logic [BLINK_DIV_W:0]  blink_cnt_reg;
    logic [15:0]           score_reg, high_reg;
    logic [15:0]           score_inc;
    logic                  score_sat;

    logic [3:0]  an_reg, an_next;
    logic [7:0]  cath_reg, cath_next;
    logic        show_high;
    logic [15:0] disp_value;
    logic [1:0]  digit_sel;
    logic [3:0]  nib [4];
    logic [7:0]  seg;

    assign lose_rise = lose && !lose_d_reg;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= PLAY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PLAY:    if (lose_rise) state_next = OVER;
            OVER:    if (clear)     state_next = PLAY;
            default: state_next = PLAY;
        endcase
    end

    always_comb begin
        in_play    = (state_reg == PLAY);
        game_over  = (state_reg == OVER);
        enter_over = in_play && lose_rise;
    end

    bcd_inc4 u_score_inc (
        .value      (score_reg),
        .value_next (score_inc),
        .saturated  (score_sat)
    );

    // High score is compared one cycle after entering OVER, so it lags game_over by a cycle.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            lose_d_reg     <= 1'b0;
            over_entry_reg <= 1'b0;
            score_reg      <= 16'h0000;
            high_reg       <= 16'h0000;
        end else begin
            lose_d_reg     <= lose;
            over_entry_reg <= enter_over;
            if (clear) begin
                score_reg <= 16'h0000;
            end else if (in_play && score_pulse && !score_sat) begin
                score_reg <= score_inc;
            end
            if (over_entry_reg && (score_reg > high_reg)) begin
                high_reg <= score_reg;
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_reg  <= '0;
            blink_cnt_reg <= '0;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
            if (game_over) begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end else begin
                blink_cnt_reg <= '0;
            end
        end
    end

    assign show_high  = game_over && blink_cnt_reg[BLINK_DIV_W];
    assign disp_value = show_high ? high_reg : score_reg;
    assign digit_sel  = scan_cnt_reg[SCAN_DIV_W+1 -: 2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign nib[gi] = disp_value[gi*4 +: 4];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] upper_zero;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lz
            assign upper_zero[gi] = ((disp_value >> (4*gi)) == 16'h0000);
        end
    endgenerate
`endif

    always_comb begin
        seg = seg_encode(nib[digit_sel]);
`ifdef LEADING_ZERO_BLANK_EN
        if ((digit_sel != DIGIT_ONES) && upper_zero[digit_sel]) begin
            seg = SEG_BLANK;
        end
`endif
        // The decimal point on the ones digit marks the high-score phase.
        cath_next = {seg[7:1], !(show_high && (digit_sel == DIGIT_ONES))};
        an_next   = ~(4'b0001 << digit_sel);
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            an_reg   <= 4'b1111;
            cath_reg <= 8'hFF;
        end else begin
            an_reg   <= an_next;
            cath_reg <= cath_next;
        end
    end

    assign An        = an_reg;
    assign Cathodes  = cath_reg;
    assign score_bcd = score_reg;
    assign high_bcd  = high_reg;

endmodule
